// File: rtl/eviction_buffer_pkg.sv
// Shared types for the L1 write-back eviction buffer.
// Line tags, buffered entry layout and FSM state encoding.
package eviction_buffer_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_8words;
    typedef logic [11:0]  lc3b_line_tag;

    typedef struct packed {
        lc3b_line_tag tag;
        lc3b_8words   data;
    } evb_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        RD_MEM,
        WR_MEM,
        RESP
    } evb_state_t;

    function automatic lc3b_line_tag line_tag(input lc3b_word addr);
        return addr[15:4];
    endfunction

    function automatic lc3b_word line_addr(input lc3b_line_tag tag);
        return {tag, 4'b0000};
    endfunction

endpackage

// File: rtl/evb_fifo.sv
// Circular line store for the eviction buffer.
// Tracks head/tail/count and does a parallel tag lookup.
module evb_fifo
    import eviction_buffer_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  lc3b_line_tag push_tag,
    input  lc3b_8words   push_data,
    input  logic         pop,
    input  logic         ovr,
    input  logic [AW-1:0] ovr_idx,
    input  lc3b_8words   ovr_data,
    input  lc3b_line_tag lookup_tag,
    output logic         match,
    output logic [AW-1:0] match_idx,
    output lc3b_8words   match_data,
    output lc3b_line_tag head_tag,
    output lc3b_8words   head_data,
    output logic [AW:0]  count,
    output logic         full,
    output logic         empty
);

    evb_entry_t     entries [DEPTH];
    logic [AW-1:0]  head;
    logic [AW-1:0]  tail;
    logic [DEPTH-1:0] vld;

    // An entry is live when its distance from head is below count.
    always_comb begin
        vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            vld[i] = ({1'b0, AW'(AW'(i) - head)} < count);
        end
    end

    // Parallel tag compare; coalescing keeps any hit unique.
    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && entries[i].tag == lookup_tag) begin
                match     = 1'b1;
                match_idx = AW'(i);
            end
        end
    end

    assign match_data = entries[match_idx].data;
    assign head_tag   = entries[head].tag;
    assign head_data  = entries[head].data;
    assign full       = (count == (AW+1)'(DEPTH));
    assign empty      = (count == '0);

    // Line storage: append at tail or rewrite a hit in place.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[tail] <= '{tag: push_tag, data: push_data};
        end
        if (ovr) begin
            entries[ovr_idx].data <= ovr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + AW'(1);
            end
            if (pop) begin
                head <= head + AW'(1);
            end
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

endmodule

// File: rtl/eviction_buffer.sv
// Write-back buffer between the L1 cache and physical memory.
// Absorbs evictions, forwards read hits, drains when idle.
module eviction_buffer
    import eviction_buffer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [15:0]  mem_address,
    input  logic [127:0] mem_wdata,
    output logic         mem_resp,
    output logic [127:0] mem_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic         pmem_resp,
    input  logic [127:0] pmem_rdata
);

    localparam int AW = $clog2(DEPTH);

    evb_state_t     state;
    evb_state_t     state_n;
    logic           resp_n;
    lc3b_8words     rdata_n;
    logic           pread_n;
    logic           pwrite_n;
    lc3b_word       paddr_n;
    lc3b_8words     pwdata_n;

    logic           push;
    logic           pop;
    logic           ovr;
    logic           match;
    logic [AW-1:0]  match_idx;
    lc3b_8words     match_data;
    lc3b_line_tag   head_tag;
    lc3b_8words     head_data;
    logic [AW:0]    count;
    logic           full;
    logic           empty;
    lc3b_line_tag   req_tag;
    logic           unused_low;

    assign req_tag    = line_tag(mem_address);
    assign unused_low = ^{mem_address[3:0], count};

    evb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_tag  (req_tag),
        .push_data (mem_wdata),
        .pop       (pop),
        .ovr       (ovr),
        .ovr_idx   (match_idx),
        .ovr_data  (mem_wdata),
        .lookup_tag(req_tag),
        .match     (match),
        .match_idx (match_idx),
        .match_data(match_data),
        .head_tag  (head_tag),
        .head_data (head_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Next state, next output register values and FIFO controls.
    always_comb begin
        state_n  = state;
        resp_n   = 1'b0;
        rdata_n  = mem_rdata;
        pread_n  = pmem_read;
        pwrite_n = pmem_write;
        paddr_n  = pmem_address;
        pwdata_n = pmem_wdata;
        push     = 1'b0;
        pop      = 1'b0;
        ovr      = 1'b0;
        unique case (state)
            IDLE: begin
                if (mem_write) begin
                    if (match) begin
                        ovr     = 1'b1;
                        resp_n  = 1'b1;
                        state_n = RESP;
                    end else if (!full) begin
                        push    = 1'b1;
                        resp_n  = 1'b1;
                        state_n = RESP;
                    end else begin
                        pwrite_n = 1'b1;
                        paddr_n  = line_addr(head_tag);
                        pwdata_n = head_data;
                        state_n  = WR_MEM;
                    end
                end else if (mem_read) begin
                    if (match) begin
                        rdata_n = match_data;
                        resp_n  = 1'b1;
                        state_n = RESP;
                    end else begin
                        pread_n = 1'b1;
                        paddr_n = line_addr(req_tag);
                        state_n = RD_MEM;
                    end
                end else if (!empty) begin
                    pwrite_n = 1'b1;
                    paddr_n  = line_addr(head_tag);
                    pwdata_n = head_data;
                    state_n  = WR_MEM;
                end
            end
            RD_MEM: begin
                if (pmem_resp) begin
                    rdata_n = pmem_rdata;
                    pread_n = 1'b0;
                    resp_n  = 1'b1;
                    state_n = RESP;
                end
            end
            WR_MEM: begin
                if (pmem_resp) begin
                    pop      = 1'b1;
                    pwrite_n = 1'b0;
                    state_n  = IDLE;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any pmem transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            mem_resp     <= 1'b0;
            mem_rdata    <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            state        <= state_n;
            mem_resp     <= resp_n;
            mem_rdata    <= rdata_n;
            pmem_read    <= pread_n;
            pmem_write   <= pwrite_n;
            pmem_address <= paddr_n;
            pmem_wdata   <= pwdata_n;
        end
    end

endmodule

// File: tb/tb_eviction_buffer.sv
// Directed self-checking bench for eviction_buffer.
// Linear stimulus with hand-computed expectations.
module tb_eviction_buffer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mem_read;
    logic         mem_write;
    logic [15:0]  mem_address;
    logic [127:0] mem_wdata;
    logic         mem_resp;
    logic [127:0] mem_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] DA = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    localparam logic [127:0] DB = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
    localparam logic [127:0] DX = 128'h1111_1111_1111_1111_1111_1111_1111_1111;
    localparam logic [127:0] DY = 128'h2222_2222_2222_2222_2222_2222_2222_2222;
    localparam logic [127:0] DZ = 128'h3333_3333_3333_3333_3333_3333_3333_3333;
    localparam logic [127:0] DR = 128'hcafe_f00d_cafe_f00d_cafe_f00d_cafe_f00d;
    localparam logic [127:0] DW = 128'h5555_aaaa_5555_aaaa_5555_aaaa_5555_aaaa;
    localparam logic [127:0] DQ = 128'h0f0f_0f0f_f0f0_f0f0_0f0f_0f0f_f0f0_f0f0;

    eviction_buffer #(.DEPTH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_resp    (mem_resp),
        .mem_rdata   (mem_rdata),
        .pmem_read   (pmem_read),
        .pmem_write  (pmem_write),
        .pmem_address(pmem_address),
        .pmem_wdata  (pmem_wdata),
        .pmem_resp   (pmem_resp),
        .pmem_rdata  (pmem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(mem_read && mem_write)) else begin
                errors++;
                $error("FAIL rw_overlap: read and write both high");
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cache_write(input logic [15:0] addr,
                               input logic [127:0] data,
                               output int lat);
        mem_write   = 1'b1;
        mem_address = addr;
        mem_wdata   = data;
        lat = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            lat++;
            if (mem_resp) break;
        end
        chk("wr_resp", 128'(mem_resp), 128'd1);
        mem_write = 1'b0;
        tick();
    endtask

    task automatic drain_expect(input string tag, input logic [15:0] addr,
                                input logic [127:0] data);
        for (int i = 0; i < 8 && !pmem_write; i++) tick();
        chk({tag, "_wr"}, 128'(pmem_write), 128'd1);
        chk({tag, "_addr"}, 128'(pmem_address), 128'(addr));
        chk({tag, "_data"}, pmem_wdata, data);
        tick();
        chk({tag, "_hold"}, 128'(pmem_write), 128'd1);
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        chk({tag, "_done"}, 128'(pmem_write), 128'd0);
    endtask

    initial begin
        int lat;
        rst_n       = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        pmem_resp   = 1'b0;
        pmem_rdata  = '0;
        tick();
        tick();
        chk("rst_resp", 128'(mem_resp), 128'd0);
        chk("rst_rdata", mem_rdata, 128'd0);
        chk("rst_pread", 128'(pmem_read), 128'd0);
        chk("rst_pwrite", 128'(pmem_write), 128'd0);
        chk("rst_paddr", 128'(pmem_address), 128'd0);
        chk("rst_pwdata", pmem_wdata, 128'd0);
        chk("rst_count", 128'(dut.u_fifo.count), 128'd0);
        rst_n = 1'b1;

        cache_write(16'h1230, DA, lat);
        chk("t1_lat", 128'(lat), 128'd1);
        drain_expect("t1_drain", 16'h1230, DA);
        chk("t1_count", 128'(dut.u_fifo.count), 128'd0);

        cache_write(16'h1230, DA, lat);
        mem_read    = 1'b1;
        mem_address = 16'h1238;
        tick();
        chk("t2_resp", 128'(mem_resp), 128'd1);
        chk("t2_rdata", mem_rdata, DA);
        chk("t2_no_pread", 128'(pmem_read), 128'd0);
        mem_read = 1'b0;
        tick();
        drain_expect("t2_drain", 16'h1230, DA);

        cache_write(16'h2000, DA, lat);
        cache_write(16'h2000, DB, lat);
        chk("t3_count", 128'(dut.u_fifo.count), 128'd1);
        drain_expect("t3_drain", 16'h2000, DB);
        tick();
        tick();
        tick();
        chk("t3_once", 128'(pmem_write), 128'd0);
        chk("t3_empty", 128'(dut.u_fifo.count), 128'd0);

        cache_write(16'h1000, DX, lat);
        cache_write(16'h2000, DY, lat);
        chk("t4_full", 128'(dut.u_fifo.count), 128'd2);
        mem_write   = 1'b1;
        mem_address = 16'h3000;
        mem_wdata   = DZ;
        tick();
        chk("t4_ev_wr", 128'(pmem_write), 128'd1);
        chk("t4_ev_addr", 128'(pmem_address), 128'h1000);
        chk("t4_ev_data", pmem_wdata, DX);
        chk("t4_no_resp0", 128'(mem_resp), 128'd0);
        tick();
        tick();
        chk("t4_wait_resp", 128'(mem_resp), 128'd0);
        chk("t4_wait_wr", 128'(pmem_write), 128'd1);
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        chk("t4_popped", 128'(pmem_write), 128'd0);
        chk("t4_no_resp1", 128'(mem_resp), 128'd0);
        tick();
        chk("t4_resp", 128'(mem_resp), 128'd1);
        mem_write = 1'b0;
        tick();
        drain_expect("t4_d1", 16'h2000, DY);
        drain_expect("t4_d2", 16'h3000, DZ);

        cache_write(16'h1000, DX, lat);
        mem_read    = 1'b1;
        mem_address = 16'h4000;
        tick();
        chk("t5_pread", 128'(pmem_read), 128'd1);
        chk("t5_paddr", 128'(pmem_address), 128'h4000);
        chk("t5_pwrite", 128'(pmem_write), 128'd0);
        tick();
        chk("t5_hold", 128'(pmem_read), 128'd1);
        chk("t5_no_resp", 128'(mem_resp), 128'd0);
        pmem_rdata = DR;
        pmem_resp  = 1'b1;
        tick();
        pmem_resp = 1'b0;
        chk("t5_resp", 128'(mem_resp), 128'd1);
        chk("t5_rdata", mem_rdata, DR);
        chk("t5_pread_off", 128'(pmem_read), 128'd0);
        mem_read = 1'b0;
        tick();
        chk("t5_rdata_hold", mem_rdata, DR);
        chk("t5_resp_off", 128'(mem_resp), 128'd0);
        drain_expect("t5_drain", 16'h1000, DX);

        cache_write(16'h5000, DW, lat);
        tick();
        chk("t6_draining", 128'(pmem_write), 128'd1);
        rst_n = 1'b0;
        tick();
        chk("t6_pwrite", 128'(pmem_write), 128'd0);
        chk("t6_resp", 128'(mem_resp), 128'd0);
        chk("t6_count", 128'(dut.u_fifo.count), 128'd0);
        rst_n       = 1'b1;
        mem_read    = 1'b1;
        mem_address = 16'h5000;
        tick();
        chk("t6_pread", 128'(pmem_read), 128'd1);
        chk("t6_paddr", 128'(pmem_address), 128'h5000);
        pmem_rdata = DQ;
        pmem_resp  = 1'b1;
        tick();
        pmem_resp = 1'b0;
        chk("t6_rresp", 128'(mem_resp), 128'd1);
        chk("t6_rdata", mem_rdata, DQ);
        mem_read = 1'b0;
        tick();
        tick();
        chk("t6_no_drain", 128'(pmem_write), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
